// File: rtl/bin2dec_pkg.sv
// Shared types and constants for the sequential binary-to-decimal display controller:
// FSM states, datapath widths, active-low segment patterns and the double-dabble step.
package bin2dec_pkg;

  localparam int W_IN  = 9;
  localparam int N_DIG = 3;
  localparam int BCD_W = 4 * N_DIG;
  localparam int SR_W  = BCD_W + W_IN;
  localparam int CNT_W = $clog2(W_IN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Segment index 0 is segment a; a 0 lights the segment.
  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // One double-dabble iteration: correct every BCD nibble independently, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int i = 0; i < N_DIG; i++) begin
      t[W_IN+4*i +: 4] = add3(sr[W_IN+4*i +: 4]);
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2dec_seq_ctrl_if.sv
// Switch/handshake/display bundle between a board top-level and bin2dec_seq_ctrl.
interface bin2dec_seq_ctrl_if;

  logic [bin2dec_pkg::W_IN-1:0] SW;
  logic                         START;
  logic                         BUSY;
  logic                         DONE;
  logic [0:6]                   HEX0;
  logic [0:6]                   HEX1;
  logic [0:6]                   HEX2;

  modport master (output SW, START, input BUSY, DONE, HEX0, HEX1, HEX2);
  modport slave  (input SW, START, output BUSY, DONE, HEX0, HEX1, HEX2);

endinterface

// File: rtl/bin2dec_seq_ctrl_seg7_dec.sv
// Combinational BCD digit to active-low 7-segment decoder; codes 10-15 blank the display.
module seg7_dec
  import bin2dec_pkg::*;
(
  input  logic [3:0] digit_i,
  output seg_t       seg_o
);

  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin2dec_seq_ctrl.sv
// Iterative double-dabble converter driving three registered 7-segment digits.
// Optional macro BIN2DEC_AUTO_CONV_EN: self-start whenever SW differs from the last converted value.
module bin2dec_seq_ctrl
  import bin2dec_pkg::*;
(
  input logic               CLOCK_50,
  input logic               RST_N,
  bin2dec_seq_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] dig_q, dig_d;
  logic             done_q, done_d;
  logic             start_req;

`ifdef BIN2DEC_AUTO_CONV_EN
  logic [W_IN-1:0] last_q, last_d;

  assign start_req = bus.START || (bus.SW != last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && start_req) last_d = bus.SW;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) last_q <= '0;
    else        last_q <= last_d;
  end
`else
  assign start_req = bus.START;
`endif

  // Digits and the DONE pulse are committed on the DONE->IDLE edge, after the last shift settles.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          sr_d    = {{BCD_W{1'b0}}, bus.SW};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = dd_step(sr_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W_IN - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        dig_d   = sr_q[SR_W-1 -: BCD_W];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!RST_N) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
    end
  end

  assign bus.BUSY = (state_q != ST_IDLE);
  assign bus.DONE = done_q;

  seg7_dec u_seg0 (.digit_i(dig_q[3:0]),  .seg_o(bus.HEX0));
  seg7_dec u_seg1 (.digit_i(dig_q[7:4]),  .seg_o(bus.HEX1));
  seg7_dec u_seg2 (.digit_i(dig_q[11:8]), .seg_o(bus.HEX2));

endmodule
